// File: rtl/xor_selftest_ctrl_if.sv
// Handshake/status bundle between the XOR self-test controller, the gate
// under test and the top-level test logic.
interface xor_selftest_ctrl_if #(
  parameter int ERR_W = 3
) ();
  logic             start;
  logic             xor_out;
  logic             xor_a;
  logic             xor_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       fail_vec;

  // master: test/status logic plus the gate output; slave: the controller
  modport master (
    output start, xor_out,
    input  xor_a, xor_b, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    input  start, xor_out,
    output xor_a, xor_b, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/xor_selftest_ctrl.sv
// Self-test sequencer for an external 2-input XOR gate: walks a/b through
// 00,01,10,11, samples the gate on the last hold cycle and reports results.
module xor_selftest_ctrl #(
  parameter int HOLD_CYCLES = 2,
  parameter int ERR_W       = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  xor_selftest_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t           state, state_next;
  logic [1:0]       idx, idx_next;
  logic [7:0]       hold_cnt, hold_next;
  logic [ERR_W-1:0] err_cnt, err_next;
  logic [3:0]       fail_vec, fail_next;
  logic             pass, pass_next;
  logic             busy, busy_next;
  logic             done, done_next;
  logic             xa, xa_next;
  logic             xb, xb_next;
  logic             last_hold;
  logic             mismatch;

  assign last_hold = (hold_cnt == HOLD_LAST);
  assign mismatch  = (bus.xor_out != (idx[1] ^ idx[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      hold_cnt <= '0;
      err_cnt  <= '0;
      fail_vec <= '0;
      pass     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      xa       <= 1'b0;
      xb       <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      hold_cnt <= hold_next;
      err_cnt  <= err_next;
      fail_vec <= fail_next;
      pass     <= pass_next;
      busy     <= busy_next;
      done     <= done_next;
      xa       <= xa_next;
      xb       <= xb_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    hold_next  = hold_cnt;
    err_next   = err_cnt;
    fail_next  = fail_vec;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = APPLY;
          idx_next   = '0;
          hold_next  = '0;
          err_next   = '0;
          fail_next  = '0;
        end
      end
      APPLY: begin
        if (last_hold) begin
          if (mismatch) begin
            fail_next[idx] = 1'b1;
            if (err_cnt != '1)
              err_next = err_cnt + 1'b1;
          end
          hold_next = '0;
          if (idx == 2'd3) begin
            state_next = DONE;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line
  // up cycle-for-cycle with the state register.
  always_comb begin
    busy_next = (state_next == APPLY);
    done_next = (state_next == DONE);
    xa_next   = busy_next & idx_next[1];
    xb_next   = busy_next & idx_next[0];
    pass_next = pass;
    if (state == IDLE && bus.start)
      pass_next = 1'b0;
    if (state_next == DONE)
      pass_next = (fail_next == 4'b0000);
  end

  assign bus.xor_a    = xa;
  assign bus.xor_b    = xb;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pass     = pass;
  assign bus.err_cnt  = err_cnt;
  assign bus.fail_vec = fail_vec;

endmodule

// File: tb/tb_xor_selftest_ctrl.sv
// Bench for xor_selftest_ctrl: three instances (HOLD/ERR_W variants) with
// behavioural gate models, a results scoreboard and timing checks.
module tb_xor_selftest_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   mode0;
  int   sel;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  xor_selftest_ctrl_if #(.ERR_W(3)) if0 ();
  xor_selftest_ctrl_if #(.ERR_W(1)) if1 ();
  xor_selftest_ctrl_if #(.ERR_W(3)) if2 ();

  xor_selftest_ctrl #(.HOLD_CYCLES(2), .ERR_W(3)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  xor_selftest_ctrl #(.HOLD_CYCLES(2), .ERR_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  xor_selftest_ctrl #(.HOLD_CYCLES(1), .ERR_W(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // gate models: mode 0 ideal XOR, 1 stuck-at-0, 2 XNOR
  assign if0.xor_out = (mode0 == 0) ? (if0.xor_a ^ if0.xor_b) :
                       (mode0 == 1) ? 1'b0 : ~(if0.xor_a ^ if0.xor_b);
  assign if1.xor_out = ~(if1.xor_a ^ if1.xor_b);
  assign if2.xor_out = if2.xor_a ^ if2.xor_b;

  logic       busy_s, done_s, pass_s, a_s, b_s;
  logic [2:0] err_s;
  logic [3:0] fail_s;

  always_comb begin
    busy_s = if0.busy; done_s = if0.done; pass_s = if0.pass;
    a_s = if0.xor_a; b_s = if0.xor_b; err_s = if0.err_cnt; fail_s = if0.fail_vec;
    if (sel == 1) begin
      busy_s = if1.busy; done_s = if1.done; pass_s = if1.pass;
      a_s = if1.xor_a; b_s = if1.xor_b; err_s = {2'b00, if1.err_cnt}; fail_s = if1.fail_vec;
    end else if (sel == 2) begin
      busy_s = if2.busy; done_s = if2.done; pass_s = if2.pass;
      a_s = if2.xor_a; b_s = if2.xor_b; err_s = if2.err_cnt; fail_s = if2.fail_vec;
    end
  end

  typedef struct {
    int         err;
    logic [3:0] fail;
    logic       pass;
  } res_t;

  typedef struct {
    int         d;
    int         mode;
    int         err;
    logic [3:0] fail;
    logic       pass;
    int         hold;
    int         restart;
  } vec_t;

  res_t sb[$];
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0: if0.start = v;
      1: if1.start = v;
      default: if2.start = v;
    endcase
  endtask

  // scoreboard consumer: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done_s) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("err_cnt", int'(err_s), e.err);
        chk("fail_vec", int'(fail_s), int'(e.fail));
        chk("pass", int'(pass_s), int'(e.pass));
      end
    end
  end

  task automatic run(input vec_t v);
    int c, nbusy, done_at, ab_bad, ix;
    sel   = v.d;
    mode0 = v.mode;
    sb.push_back('{v.err, v.fail, v.pass});
    set_start(v.d, 1'b1);
    @(negedge clk);
    set_start(v.d, 1'b0);
    nbusy = 0; done_at = -1; ab_bad = 0; c = 0;
    while (done_at < 0 && c < 60) begin
      if (c == v.restart) set_start(v.d, 1'b1);
      if (v.restart >= 0 && c == v.restart + 1) set_start(v.d, 1'b0);
      if (busy_s) begin
        nbusy++;
        ix = c / v.hold;
        if ({a_s, b_s} != ix[1:0]) ab_bad++;
      end else if (a_s | b_s) begin
        ab_bad++;
      end
      if (done_s) done_at = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk("busy_cycles", nbusy, 4 * v.hold);
    chk("done_at", done_at, 4 * v.hold);
    chk("ab_seq", ab_bad, 0);
    @(negedge clk);
    chk("done_width", int'({done_s, busy_s}), 0);
    if (v.restart >= 0) begin
      nbusy = 0;
      repeat (6) begin
        @(negedge clk);
        if (busy_s | done_s) nbusy++;
      end
      chk("restart_ignored", nbusy, 0);
    end
  endtask

  initial begin
    int c1, c2, got, cnt;
    logic [8:0] snap;
    rst_n = 1'b0;
    mode0 = 0; sel = 0;
    if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;

    tbl[0] = '{0, 0, 0, 4'b0000, 1'b1, 2, -1};
    tbl[1] = '{0, 1, 2, 4'b0110, 1'b0, 2, -1};
    tbl[2] = '{0, 2, 4, 4'b1111, 1'b0, 2, -1};
    tbl[3] = '{1, 2, 1, 4'b1111, 1'b0, 2, -1};
    tbl[4] = '{0, 0, 0, 4'b0000, 1'b1, 2, 3};
    tbl[5] = '{2, 0, 0, 4'b0000, 1'b1, 1, -1};

    repeat (3) @(negedge clk);
    chk("reset_dut0", int'({if0.busy, if0.done, if0.pass, if0.xor_a, if0.xor_b, if0.err_cnt, if0.fail_vec}), 0);
    chk("reset_dut1", int'({if1.busy, if1.done, if1.pass, if1.xor_a, if1.xor_b, if1.err_cnt, if1.fail_vec}), 0);
    chk("reset_dut2", int'({if2.busy, if2.done, if2.pass, if2.xor_a, if2.xor_b, if2.err_cnt, if2.fail_vec}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run(tbl[i]);
      repeat (2) @(negedge clk);
    end

    // results must hold while idle
    sel = 2;
    snap = {pass_s, err_s, fail_s, done_s};
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if ({pass_s, err_s, fail_s, done_s} != snap || busy_s) cnt++;
    end
    chk("results_hold", cnt, 0);

    // start held high: back-to-back runs with one idle cycle in between
    sel = 0; mode0 = 0;
    sb.push_back('{0, 4'b0000, 1'b1});
    sb.push_back('{0, 4'b0000, 1'b1});
    if0.start = 1'b1;
    @(negedge clk);
    c1 = -1; c2 = -1;
    for (int c = 0; c < 60; c++) begin
      if (c1 < 0 && done_s) c1 = c;
      else if (c1 >= 0 && busy_s) begin
        c2 = c;
        break;
      end
      @(negedge clk);
    end
    if0.start = 1'b0;
    chk("b2b_first_done", c1, 8);
    chk("b2b_gap", c2 - c1, 2);
    got = 0;
    for (int k = 0; k < 30; k++) begin
      if (done_s) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_second_done", got, 1);
    repeat (4) @(negedge clk);

    // asynchronous reset during vector 2 with a faulty gate
    mode0 = 1;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_err", int'(err_s), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", int'({if0.busy, if0.done, if0.pass, if0.xor_a, if0.xor_b, if0.err_cnt, if0.fail_vec}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy_s | done_s) cnt++;
    end
    chk("post_reset_idle", cnt, 0);
    run(tbl[0]);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xor_selftest_ctrl.md
Name: xor_selftest_ctrl

Overview:
- Built-in self-test sequencer for the 2-input XOR gate datapath.
- On a start request it drives the gate's a/b inputs through all four combinations in a fixed order and holds each for a programmable number of cycles.
- It samples the gate output, compares it against the expected XOR value, and reports done/pass, an error count and a per-vector fail mask.
- Sits between the gate instance and the top-level test/status logic; the gate itself stays combinational and external.

Parameters:
HOLD_CYCLES, 2, cycles each vector is held on xor_a/xor_b (legal range 1..255)
ERR_W, 3, width of the saturating error counter (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request; sampled only in IDLE
xor_out  input  1  output of the external XOR gate under test
xor_a  output  1  drive to gate input a
xor_b  output  1  drive to gate input b
busy  output  1  high while a run is in progress (APPLY state)
done  output  1  one-cycle pulse at end of run
pass  output  1  1 = last run had zero mismatches; held until next accepted start
err_cnt  output  ERR_W  mismatch count of last/current run, saturating
fail_vec  output  4  bit i set if vector i mismatched

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; FSM in IDLE; vector index 0; hold counter 0.
- Vector order: idx 0..3 gives {xor_a,xor_b} = {idx[1],idx[0]}, i.e. 00, 01, 10, 11. Expected value = xor_a ^ xor_b.
- Outputs are registered; xor_a/xor_b are 0 in IDLE and DONE.
- FSM has three states: IDLE, APPLY, DONE.
- IDLE:
  - start=1 at a rising edge: go to APPLY with idx=0 and hold_cnt=0.
  - At the same edge, clear err_cnt, fail_vec and pass.
  - start=0: stay in IDLE.
- APPLY:
  - busy=1; xor_a/xor_b driven from idx.
  - hold_cnt increments each cycle.
  - On the edge where hold_cnt==HOLD_CYCLES-1, sample xor_out:
    - If it differs from expected, set fail_vec[idx] and increment err_cnt (saturate at 2^ERR_W-1, no wrap).
    - Then, if idx==3, go to DONE; otherwise idx+1 and hold_cnt=0.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - pass=1 iff no mismatch was recorded in this run (fail_vec==0; independent of err_cnt saturation).
  - Next state is IDLE unconditionally.
- Timing: start accepted at edge E0. busy is high for 4*HOLD_CYCLES cycles. done is high in the cycle after edge E0+4*HOLD_CYCLES (HOLD=2: 8 busy cycles, then 1 done cycle).
- start is ignored in APPLY and DONE; there is no queuing. A start held high continuously re-launches the run on the first IDLE cycle after DONE.
- Results: pass, err_cnt and fail_vec remain stable after DONE until the next accepted start. During a run, err_cnt and fail_vec update live.
- Sampling: only the final hold cycle of each vector is compared. Earlier cycles give the combinational gate settling time. With HOLD_CYCLES=1, sampling happens in the single cycle the vector is driven.
- Reset mid-run (rst_n low at any time): immediate return to reset values. No done pulse; partial results are discarded.
- xor_out is treated as synchronous to clk; there is no synchroniser.

Test Plan:
1. HOLD=2, ideal XOR model, one start pulse:
   - a/b sequence 00,01,10,11, each exactly 2 cycles.
   - busy high for 8 cycles, then done for 1 cycle.
   - pass=1, err_cnt=0, fail_vec=0000.
2. Gate model stuck-at-0 output -> err_cnt=2, fail_vec=0110, pass=0; done timing identical to scenario 1.
3. Gate model replaced by XNOR:
   - ERR_W=3: err_cnt=4, fail_vec=1111, pass=0.
   - Rerun with ERR_W=1: err_cnt=1 (saturated), fail_vec=1111, pass=0.
4. start pulsed again mid-run (cycle 3 of APPLY) -> ignored; single done pulse at the original time. start held high continuously -> back-to-back runs with one IDLE cycle between a done pulse and the next busy.
5. rst_n asserted during vector 2 -> all outputs 0 within the same cycle (asynchronous), no done pulse. After release plus a new start, a full clean run with pass=1.
6. HOLD_CYCLES=1 with an ideal model -> 4 busy cycles, done in the 5th cycle after acceptance, pass=1; results hold unchanged for 20 idle cycles.
